// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Command-driven controller for an 8-bit programmable up/down counter.
//   Commands (LOAD / COUNT_UP / COUNT_DOWN / STOP) arrive over a valid/ready
//   handshake and are turned into registered, single-cycle strobes on the
//   counter's enable, clock, load, direction and parallel-data pins.
//
//   Optional feature macro: CNTSEQ_AUTORELOAD_EN
//     defined   - a COUNT_* command restarts with the same N and direction
//                 after each completed run (done pulses every run) until abort.
//     undefined - single-shot commands; no reload register exists.
//
// Parameters
//   WIDTH     width of cmd_arg / cnt_data and of the step counter
//   STEP_GAP  cycles cnt_clk stays low after each count strobe (1..15)
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   cmd_valid     command present
//   cmd_ready     high only in IDLE; accept = cmd_valid & cmd_ready
//   cmd_op        00 STOP, 01 LOAD, 10 COUNT_UP, 11 COUNT_DOWN
//   cmd_arg       LOAD value or step count N
//   abort         end the current command at the next strobe boundary
//   cnt_enable    counter enable / counter bus output enable
//   cnt_clk       one-cycle count/load strobes
//   cnt_load      parallel-load select
//   cnt_up_down   1 = up, 0 = down
//   cnt_data      parallel load value
//   busy          high outside IDLE
//   done          one-cycle pulse on completion, abort, or (auto-reload) each run
module counter_sequencer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STEP_GAP = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             abort,
    output logic             cnt_enable,
    output logic             cnt_clk,
    output logic             cnt_load,
    output logic             cnt_up_down,
    output logic [WIDTH-1:0] cnt_data,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;

    localparam logic [3:0] GAP_LAST = 4'(STEP_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_SETUP,
        S_LD_STROBE,
        S_LD_HOLD,
        S_STEP_HI,
        S_STEP_LO,
        S_FINISH
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] step_q;      // count strobes still to be issued
    logic [3:0]       gap_q;       // low cycles left after the current strobe
    logic             cmd_ready_q;
    logic             cnt_enable_q;
    logic             cnt_clk_q;
    logic             cnt_load_q;
    logic             cnt_up_down_q;
    logic [WIDTH-1:0] cnt_data_q;
    logic             busy_q;
    logic             done_q;
`ifdef CNTSEQ_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q;    // original N, restored at the end of each run
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            step_q        <= '0;
            gap_q         <= '0;
            cmd_ready_q   <= 1'b0;
            cnt_enable_q  <= 1'b0;
            cnt_clk_q     <= 1'b0;
            cnt_load_q    <= 1'b0;
            cnt_up_down_q <= 1'b1;
            cnt_data_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef CNTSEQ_AUTORELOAD_EN
            reload_q      <= '0;
`endif
        end else begin
            // Strobes default low so every high is exactly one cycle.
            cnt_clk_q <= 1'b0;
            done_q    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        if (cmd_op == OP_STOP) begin
                            cnt_enable_q <= 1'b0;
                        end else if (cmd_op == OP_LOAD) begin
                            cnt_enable_q <= 1'b1;
                            cnt_data_q   <= cmd_arg;
                            cnt_load_q   <= 1'b1;
                            cmd_ready_q  <= 1'b0;
                            busy_q       <= 1'b1;
                            state_q      <= S_LD_SETUP;
                        end else begin
                            cnt_enable_q  <= 1'b1;
                            cnt_up_down_q <= (cmd_op == OP_UP);
                            step_q        <= cmd_arg;
`ifdef CNTSEQ_AUTORELOAD_EN
                            reload_q      <= cmd_arg;
`endif
                            cmd_ready_q   <= 1'b0;
                            busy_q        <= 1'b1;
                            if (cmd_arg == '0) begin
                                done_q  <= 1'b1;
                                state_q <= S_FINISH;
                            end else begin
                                cnt_clk_q <= 1'b1;
                                state_q   <= S_STEP_HI;
                            end
                        end
                    end
                end

                S_LD_SETUP: begin
                    if (abort) begin
                        cnt_load_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_FINISH;
                    end else begin
                        cnt_clk_q <= 1'b1;
                        state_q   <= S_LD_STROBE;
                    end
                end

                S_LD_STROBE: begin
                    if (abort) begin
                        cnt_load_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_FINISH;
                    end else begin
                        state_q <= S_LD_HOLD;
                    end
                end

                S_LD_HOLD: begin
                    cnt_load_q <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= S_FINISH;
                end

                S_STEP_HI: begin
                    // The strobe is already on the pin this cycle; abort only
                    // suppresses the following low gap and any further strobes.
                    step_q <= step_q - WIDTH'(1);
                    if (abort) begin
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end else begin
                        gap_q   <= GAP_LAST;
                        state_q <= S_STEP_LO;
                    end
                end

                S_STEP_LO: begin
                    if (abort) begin
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end else if (gap_q != '0) begin
                        gap_q <= gap_q - 4'd1;
                    end else if (step_q != '0) begin
                        cnt_clk_q <= 1'b1;
                        state_q   <= S_STEP_HI;
                    end else begin
`ifdef CNTSEQ_AUTORELOAD_EN
                        // Restart straight into the next run; done marks the
                        // run boundary without passing through FINISH.
                        step_q    <= reload_q;
                        cnt_clk_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= S_STEP_HI;
`else
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
`endif
                    end
                end

                S_FINISH: begin
                    cnt_load_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end

                default: begin
                    cnt_load_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign cnt_enable  = cnt_enable_q;
    assign cnt_clk     = cnt_clk_q;
    assign cnt_load    = cnt_load_q;
    assign cnt_up_down = cnt_up_down_q;
    assign cnt_data    = cnt_data_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer
//   Directed bench for counter_sequencer. A command-level timing model predicts
//   every output on every cycle from the time elapsed since acceptance; a
//   model of the external counter tracks the value the strobes produce.
//   Auto-reload behaviour is exercised when CNTSEQ_AUTORELOAD_EN is defined.
module tb_counter_sequencer;

    localparam int W   = 8;
    localparam int G   = 2;
    localparam int INF = 32'h3fff_ffff;
`ifdef CNTSEQ_AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_arg = '0;
    logic         abort = 1'b0;
    logic         cmd_ready, cnt_enable, cnt_clk, cnt_load, cnt_up_down, busy, done;
    logic [W-1:0] cnt_data;

    counter_sequencer #(.WIDTH(W), .STEP_GAP(G)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort),
        .cnt_enable(cnt_enable), .cnt_clk(cnt_clk), .cnt_load(cnt_load),
        .cnt_up_down(cnt_up_down), .cnt_data(cnt_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // External counter driven by the strobes.
    logic [W-1:0] ctr = '0;
    always @(posedge clk)
        if (cnt_enable && cnt_clk)
            ctr <= cnt_load ? cnt_data : (cnt_up_down ? ctr + 8'd1 : ctr - 8'd1);

    // Command timing model: m_t = cycles since acceptance, m_fin = FINISH cycle.
    logic         m_busy, m_ready, m_en, m_dir, m_load;
    logic [W-1:0] m_data;
    int           m_t, m_fin, m_n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_ready <= 1'b0; m_en <= 1'b0; m_dir <= 1'b1;
            m_load <= 1'b0; m_data <= '0; m_t <= 0; m_fin <= 0; m_n <= 0;
        end else if (m_busy) begin
            if (m_t == m_fin) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
            end else begin
                if (abort) m_fin <= m_t + 1;
                m_t <= m_t + 1;
            end
        end else if (cmd_valid && m_ready) begin
            if (cmd_op == 2'b00) begin
                m_en <= 1'b0;
            end else begin
                m_en <= 1'b1; m_busy <= 1'b1; m_ready <= 1'b0; m_t <= 0;
                m_load <= (cmd_op == 2'b01);
                if (cmd_op == 2'b01) begin
                    m_data <= cmd_arg;
                    m_fin  <= 3;
                end else begin
                    m_dir <= (cmd_op == 2'b10);
                    m_n   <= int'(cmd_arg);
                    m_fin <= (cmd_arg == 0) ? 0 : (AUTO ? INF : int'(cmd_arg) * (G + 1));
                end
            end
        end else begin
            m_ready <= 1'b1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic e_clk, e_load, e_done;
        logic [14:0] exp_v, act_v;
        e_clk = 1'b0; e_load = 1'b0; e_done = 1'b0;
        if (rst_n) begin
            if (m_busy) begin
                if (m_load) begin
                    e_load = (m_t < 3) && (m_t < m_fin);
                    e_clk  = (m_t == 1) && (m_t < m_fin);
                    e_done = (m_t == m_fin);
                end else begin
                    e_clk  = (m_t < m_fin) && (m_t % (G + 1) == 0);
                    e_done = (m_t == m_fin);
                    if (AUTO && m_n > 0 && m_t > 0 && m_t < m_fin)
                        if (m_t % (m_n * (G + 1)) == 0) e_done = 1'b1;
                end
            end
            exp_v = {m_ready, m_busy, e_done, m_en, e_clk, e_load, m_dir, m_data};
            act_v = {cmd_ready, busy, done, cnt_enable, cnt_clk, cnt_load, cnt_up_down, cnt_data};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle t=%0d: got rdy/busy/done/en/clk/load/dir=%b data=%h, expected %b data=%h",
                         m_t, act_v[14:8], act_v[7:0], exp_v[14:8], exp_v[7:0]);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [W-1:0] arg);
        bit ok;
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("accept", ok, 1);
    endtask

    task automatic wait_done(output int cyc, output int pulses, output int loads);
        cyc = 0; pulses = 0; loads = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            cyc++;
            if (cnt_clk)  pulses++;
            if (cnt_load) loads++;
            if (done) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals();
        check("rst_enable", cnt_enable, 0);
        check("rst_clk", cnt_clk, 0);
        check("rst_load", cnt_load, 0);
        check("rst_dir", cnt_up_down, 1);
        check("rst_data", cnt_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, p, l, nd, dc;
        bit seen;

        repeat (3) @(posedge clk);
        #1 check_reset_vals();
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", cmd_ready, 1);

        // Reset in the middle of COUNT_UP N=10 after four strobes.
        issue(2'b10, 8'd10);
        repeat (10) @(posedge clk);
        #1 check("ctr_before_reset", ctr, 8'h04);
        rst_n = 1'b0;
        #1 check_reset_vals();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rerelease", cmd_ready, 1);

        // LOAD 0xA5.
        issue(2'b01, 8'hA5);
        wait_done(c, p, l);
        check("load_cycles", c, 4);
        check("load_pulses", p, 1);
        check("load_high_cycles", l, 3);
        check("load_data", cnt_data, 8'hA5);
        check("ctr_after_load", ctr, 8'hA5);

        // COUNT_UP N=5.
        issue(2'b10, 8'd5);
        wait_done(c, p, l);
        check("up5_cycles", c, 16);
        check("up5_pulses", p, 5);
        check("ctr_after_up5", ctr, 8'hAA);

        // COUNT_DOWN N=0.
        issue(2'b11, 8'd0);
        wait_done(c, p, l);
        check("down0_cycles", c, 1);
        check("down0_pulses", p, 0);
        check("down0_dir", cnt_up_down, 0);
        check("ctr_after_down0", ctr, 8'hAA);

        // COUNT_UP N=200, abort in the third low gap, LOAD held pending meanwhile.
        issue(2'b10, 8'd200);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 8'h3C;
        p = 0; seen = 1'b0; dc = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            abort = (k == 7);
            @(negedge clk);
            if (cnt_clk) p++;
            if (done) begin seen = 1'b1; dc = k + 1; end
            @(posedge clk); #1;
        end
        abort = 1'b0;
        check("abort_done_cycle", dc, 9);
        check("abort_pulses", p, 3);
        check("ctr_after_abort", ctr, 8'hAD);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done(c, p, l);
        check("pending_load_cycles", c, 4);
        check("pending_load_data", cnt_data, 8'h3C);
        check("ctr_after_pending_load", ctr, 8'h3C);

`ifdef CNTSEQ_AUTORELOAD_EN
        // COUNT_DOWN N=2 repeating until abort.
        issue(2'b11, 8'd2);
        p = 0; nd = 0;
        for (int k = 0; k < 21; k++) begin
            abort = (k == 19);
            @(negedge clk);
            if (cnt_clk) p++;
            if (done) nd++;
            @(posedge clk); #1;
        end
        abort = 1'b0;
        check("auto_pulses", p, 7);
        check("auto_dones", nd, 4);
        @(negedge clk);
        check("auto_busy_end", busy, 0);
        check("ctr_after_auto", ctr, 8'h35);
        @(posedge clk); #1;
`else
        // Single step boundary: N=1.
        issue(2'b10, 8'd1);
        wait_done(c, p, l);
        check("up1_cycles", c, 4);
        check("up1_pulses", p, 1);
        check("ctr_after_up1", ctr, 8'h3D);
`endif

        // STOP clears the enable and stays idle.
        issue(2'b00, 8'd0);
        @(negedge clk);
        check("stop_enable", cnt_enable, 0);
        check("stop_busy", busy, 0);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
